// File: rtl/tone_generator.sv
// tone_generator: keyboard-to-audio stage.
// Synchronizes and debounces seven note keys, picks the lowest pressed key,
// and divides the system clock by a per-note, per-octave half-period count
// to produce a 50 % square wave on the buzzer output.
// Optional feature macro: TONE_SUSTAIN_EN adds a RELEASE state with a 25-bit
// sustain counter so the last note rings on after all keys are released.
module tone_generator #(
  parameter int DEB     = 1_000_000,
  parameter int SUSTAIN = 25_000_000
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [6:0] I_KEY,
  input  logic [1:0] I_OCT,
  output logic       O_AUDIO,
  output logic [2:0] O_NOTE,
  output logic       O_BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int            DW      = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB - 1);

`ifdef TONE_SUSTAIN_EN
  localparam logic [24:0] SUS_MAX = 25'(SUSTAIN - 1);
`endif

  logic [6:0]    keyMeta_q, keySync_q, keyPrev_q, kd_q;
  logic [DW-1:0] stab_q, stab_d;
  logic          kdLoad;
  logic [2:0]    idx;
  logic [17:0]   baseHalf, newHalf;

  state_t        state_q, state_d;
  logic [17:0]   half_q, half_d;
  logic [17:0]   tone_q, tone_d;
  logic          audio_q, audio_d;
  logic [2:0]    note_q, note_d;
  logic          toneWrap;
  logic [17:0]   toneRun;
  logic          audioRun;
`ifdef TONE_SUSTAIN_EN
  logic [24:0]   sus_q, sus_d;
`endif

  // Two-flop synchronizer, previous-value register and accepted-key register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      keyMeta_q <= '0;
      keySync_q <= '0;
      keyPrev_q <= '0;
      stab_q    <= '0;
      kd_q      <= '0;
    end else begin
      keyMeta_q <= I_KEY;
      keySync_q <= keyMeta_q;
      keyPrev_q <= keySync_q;
      stab_q    <= stab_d;
      if (kdLoad) kd_q <= keySync_q;
    end
  end

  // Stability counter: restarts on any change and saturates once accepted.
  always_comb begin
    stab_d = stab_q;
    if (keySync_q != keyPrev_q) stab_d = '0;
    else if (stab_q != DEB_MAX) stab_d = stab_q + DW'(1);
    kdLoad = (stab_d == DEB_MAX);
  end

  // Lowest pressed key wins; descending scan lets the lowest bit overwrite.
  always_comb begin
    idx = '0;
    for (int i = 6; i >= 0; i--) begin
      if (kd_q[i]) idx = 3'(i + 1);
    end
  end

  // Half-period lookup for the fourth octave, shifted down by the octave input.
  always_comb begin
    case (idx)
      3'd1:    baseHalf = 18'd191110;
      3'd2:    baseHalf = 18'd170265;
      3'd3:    baseHalf = 18'd151685;
      3'd4:    baseHalf = 18'd143171;
      3'd5:    baseHalf = 18'd127551;
      3'd6:    baseHalf = 18'd113636;
      3'd7:    baseHalf = 18'd101239;
      default: baseHalf = 18'd0;
    endcase
    newHalf = baseHalf >> I_OCT;
  end

  // State, tone divider and output registers.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      half_q  <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
      note_q  <= '0;
`ifdef TONE_SUSTAIN_EN
      sus_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      tone_q  <= tone_d;
      audio_q <= audio_d;
      note_q  <= note_d;
`ifdef TONE_SUSTAIN_EN
      sus_q   <= sus_d;
`endif
    end
  end

  // Next-state logic; a reload keeps the audio level so no short glitch appears.
  always_comb begin
    toneWrap = (tone_q == half_q - 18'd1);
    toneRun  = toneWrap ? 18'd0 : tone_q + 18'd1;
    audioRun = toneWrap ? ~audio_q : audio_q;

    state_d = state_q;
    half_d  = half_q;
    tone_d  = tone_q;
    audio_d = audio_q;
    note_d  = note_q;
`ifdef TONE_SUSTAIN_EN
    sus_d   = sus_q;
`endif

    case (state_q)
      IDLE: begin
        audio_d = 1'b0;
        note_d  = '0;
        tone_d  = '0;
        if (idx != 3'd0) begin
          state_d = PLAY;
          half_d  = newHalf;
          tone_d  = '0;
          note_d  = idx;
        end
      end
      PLAY: begin
        if (idx == 3'd0) begin
`ifdef TONE_SUSTAIN_EN
          state_d = RELEASE;
          sus_d   = '0;
          tone_d  = toneRun;
          audio_d = audioRun;
`else
          state_d = IDLE;
          tone_d  = '0;
          audio_d = 1'b0;
          note_d  = '0;
`endif
        end else if (idx != note_q) begin
          half_d = newHalf;
          tone_d = '0;
          note_d = idx;
        end else begin
          tone_d  = toneRun;
          audio_d = audioRun;
        end
      end
`ifdef TONE_SUSTAIN_EN
      RELEASE: begin
        if (idx != 3'd0) begin
          state_d = PLAY;
          half_d  = newHalf;
          tone_d  = '0;
          note_d  = idx;
        end else if (sus_q == SUS_MAX) begin
          state_d = IDLE;
          tone_d  = '0;
          audio_d = 1'b0;
          note_d  = '0;
        end else begin
          sus_d   = sus_q + 25'd1;
          tone_d  = toneRun;
          audio_d = audioRun;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        audio_d = 1'b0;
        note_d  = '0;
        tone_d  = '0;
      end
    endcase
  end

  assign O_AUDIO = audio_q;
  assign O_NOTE  = note_q;
  assign O_BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized checks of tone_generator against a
// note/half-period reference computed from the key priority and octave rules.
// Honors TONE_SUSTAIN_EN the same way as the design.
module tb_tone_generator;

  localparam int DEB     = 4;
  localparam int SUSTAIN = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] key = '0;
  logic [1:0] oct = '0;
  logic       audio;
  logic [2:0] note;
  logic       busy;

  int testsRun    = 0;
  int testsFailed = 0;
  int lastNote    = 0;

  tone_generator #(.DEB(DEB), .SUSTAIN(SUSTAIN)) dut (
    .I_CLK  (clk),
    .I_RST  (rst),
    .I_KEY  (key),
    .I_OCT  (oct),
    .O_AUDIO(audio),
    .O_NOTE (note),
    .O_BUSY (busy)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Reference: lowest pressed key gives note 1..7, none gives 0.
  function automatic int refNote(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  // Reference: fourth-octave half period divided by 2**octave.
  function automatic int refHalf(input int n, input int o);
    int tbl[7] = '{191110, 170265, 151685, 143171, 127551, 113636, 101239};
    return tbl[n - 1] / (1 << o);
  endfunction

  task automatic waitNote(input logic [2:0] from, input int bound, output int cyc);
    cyc = 0;
    while (note === from && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic waitAudio(input logic lvl, input int bound, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (audio === lvl && cyc < bound);
  endtask

  task automatic test_reset();
    rst = 1'b1; key = '0; oct = '0;
    repeat (3) @(negedge clk);
    testsRun++; if (audio !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_audio: got %0b expected 0", audio); end
    testsRun++; if (note !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_note: got %0d expected 0", note); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_debounce();
    bit sawBusy = 0;
    int c;
    for (int p = 0; p < 4; p++) begin
      key = 7'b0000001;
      repeat (3) begin @(negedge clk); if (busy !== 1'b0) sawBusy = 1; end
      key = 7'b0000000;
      repeat (3) begin @(negedge clk); if (busy !== 1'b0) sawBusy = 1; end
    end
    repeat (10) begin @(negedge clk); if (busy !== 1'b0) sawBusy = 1; end
    testsRun++; if (sawBusy !== 1'b0) begin testsFailed++; $display("[TB] FAIL bounce_busy: got %0b expected 0", sawBusy); end

    key = 7'b0000001; oct = 2'($urandom_range(0, 3));
    repeat (6) @(negedge clk);
    testsRun++; if (note !== 3'd0) begin testsFailed++; $display("[TB] FAIL early_note: got %0d expected 0", note); end
    @(negedge clk);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL latency_note: got %0d expected %0d", note, refNote(key)); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL latency_busy: got %0b expected 1", busy); end

    key = 7'b0000000;
    repeat (6) @(negedge clk);
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL release_early: got %0b expected 1", busy); end
`ifdef TONE_SUSTAIN_EN
    c = 0;
    while (busy === 1'b1 && c < 200) begin @(negedge clk); c++; end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL release_idle: got %0b expected 0", busy); end
`else
    @(negedge clk);
    c = 0;
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL release_busy: got %0b expected 0", busy); end
    testsRun++; if (audio !== 1'b0) begin testsFailed++; $display("[TB] FAIL release_audio: got %0b expected 0", audio); end
    testsRun++; if (note !== 3'd0) begin testsFailed++; $display("[TB] FAIL release_note: got %0d expected 0 (%0d)", note, c); end
`endif
  endtask

  task automatic test_single_note();
    int c, h;
    key = 7'b0100000; oct = 2'd3;
    h = refHalf(refNote(key), 3);
    waitNote(3'd0, 20, c);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL single_note: got %0d expected %0d", note, refNote(key)); end
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy: got %0b expected 1", busy); end
    waitAudio(1'b0, h + 20, c);
    testsRun++; if (c != h) begin testsFailed++; $display("[TB] FAIL first_rise: got %0d cycles expected %0d", c, h); end
    waitAudio(1'b1, h + 20, c);
    testsRun++; if (c != h) begin testsFailed++; $display("[TB] FAIL high_time: got %0d cycles expected %0d", c, h); end
    lastNote = refNote(key);
  endtask

  task automatic test_priority();
    int c, h;
    logic lvl;
    key = 7'b0010100; oct = 2'd3;
    waitNote(3'(lastNote), 20, c);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL prio_note: got %0d expected %0d", note, refNote(key)); end
    lvl = audio;
    key = 7'b0010000;
    h = refHalf(refNote(key), 3);
    waitNote(3'd3, 20, c);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL change_note: got %0d expected %0d", note, refNote(key)); end
    testsRun++; if (audio !== lvl) begin testsFailed++; $display("[TB] FAIL change_level: got %0b expected %0b", audio, lvl); end
    waitAudio(audio, h + 20, c);
    testsRun++; if (c != h) begin testsFailed++; $display("[TB] FAIL restart_half: got %0d cycles expected %0d", c, h); end
    lastNote = refNote(key);
  endtask

  task automatic test_random();
    int c, h, n, cur;
    logic lvl;
    for (int it = 0; it < 6; it++) begin
      key = 7'($urandom_range(1, 127));
      oct = 2'($urandom_range(0, 3));
      repeat (7) @(negedge clk);
      testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL rand_note: key %b got %0d expected %0d", key, note, refNote(key)); end
      testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rand_busy: got %0b expected 1", busy); end
    end
    cur = refNote(key);
    do n = $urandom_range(1, 7); while (n == cur);
    key = 7'(($urandom_range(0, 127) << n) | (1 << (n - 1)));
    oct = 2'd3;
    h = refHalf(refNote(key), 3);
    waitNote(3'(cur), 20, c);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL rand_switch: got %0d expected %0d", note, refNote(key)); end
    lvl = audio;
    waitAudio(lvl, h + 20, c);
    testsRun++; if (c != h) begin testsFailed++; $display("[TB] FAIL rand_half: note %0d got %0d cycles expected %0d", refNote(key), c, h); end
    lastNote = refNote(key);
  endtask

`ifdef TONE_SUSTAIN_EN
  task automatic test_sustain();
    int c;
    bit sawIdle = 0;
    key = 7'b0000000;
    repeat (7) @(negedge clk);
    testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL sus_busy: got %0b expected 1", busy); end
    testsRun++; if (note !== 3'(lastNote)) begin testsFailed++; $display("[TB] FAIL sus_note: got %0d expected %0d", note, lastNote); end
    repeat (43) begin @(negedge clk); if (busy !== 1'b1) sawIdle = 1; end
    key = 7'b0000100;
    c = 0;
    while (note !== 3'(refNote(key)) && c < 20) begin
      @(negedge clk); c++;
      if (busy !== 1'b1) sawIdle = 1;
    end
    testsRun++; if (sawIdle !== 1'b0) begin testsFailed++; $display("[TB] FAIL sus_no_idle: got %0b expected 0", sawIdle); end
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL sus_repress: got %0d expected %0d", note, refNote(key)); end
    key = 7'b0000000;
    c = 0;
    while (busy === 1'b1 && c < 200) begin @(negedge clk); c++; end
    testsRun++; if (c != 2 + DEB + 1 + SUSTAIN) begin testsFailed++; $display("[TB] FAIL sus_length: got %0d expected %0d", c, 2 + DEB + 1 + SUSTAIN); end
    testsRun++; if (audio !== 1'b0) begin testsFailed++; $display("[TB] FAIL sus_audio: got %0b expected 0", audio); end
    testsRun++; if (note !== 3'd0) begin testsFailed++; $display("[TB] FAIL sus_end_note: got %0d expected 0", note); end
  endtask
`endif

  task automatic test_reset_midtone();
    int c;
    key = 7'b0000010; oct = 2'd3;
    waitNote(note, 20, c);
    testsRun++; if (note !== 3'(refNote(key))) begin testsFailed++; $display("[TB] FAIL mid_note: got %0d expected %0d", note, refNote(key)); end
    rst = 1'b1;
    @(negedge clk);
    testsRun++; if (audio !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_audio: got %0b expected 0", audio); end
    testsRun++; if (note !== 3'd0) begin testsFailed++; $display("[TB] FAIL mid_note0: got %0d expected 0", note); end
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_busy: got %0b expected 0", busy); end
    repeat (2) @(negedge clk);
    key = 7'b0000000;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", busy); end
  endtask

  // Scenario sequencer.
  initial begin
    test_reset();
    test_debounce();
    test_single_note();
    test_priority();
    test_random();
`ifdef TONE_SUSTAIN_EN
    test_sustain();
`endif
    test_reset_midtone();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
